clk_switch_ctrl: RTL and testbench
==================================

Name: clk_switch_ctrl

Overview:
Sequencer for the SCU glitch-free clock switch and the PLL feeding its clk1 input.
- Accepts software clock-select requests and enables the PLL.
- Waits for synchronised PLL lock with a timeout, then drives the switch select.
- Waits a fixed settle time before reporting the new clock and powering the PLL down.
- Runs on the always-on reference clock, which is the switch's clk0.

Parameters:
CNT_W, 16, width of the internal cycle counter
LOCK_TIMEOUT, 4096, max clk cycles waiting for lock after pll_en rises (must be < 2^CNT_W)
SETTLE_CYCLES, 16, clk cycles waited after sel_clk changes before completion (covers switch sync chain; must be >= 1)

Ports:
clk  in  1  always-on reference clock (same as switch clk0)
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  switch request valid
req_sel  in  1  requested clock: 0 = clk0/ref, 1 = clk1/PLL
req_ready  out  1  request accepted when req_valid & req_ready
pll_lock_async  in  1  PLL lock, asynchronous to clk
pll_en  out  1  PLL enable
sel_clk  out  1  select to the glitch-free switch
cur_sel  out  1  clock currently in effect (updated after settle)
busy  out  1  sequence in progress
err_timeout  out  1  sticky lock-timeout flag
err_clr  in  1  clears err_timeout and lock_lost
lock_lost  out  1  sticky lock-loss flag (feature only; else 0)

Behaviour:
- Clock and reset: one clock domain, clk; reset is asynchronous and active-low on rst_n. Every flop, including the 2-flop lock synchroniser, resets asynchronously.
- Reset values: state=IDLE, sel_clk=0, pll_en=0, cur_sel=0, busy=0, err_timeout=0, lock_lost=0, counter=0, lock_sync=0.
- pll_lock_async passes through a 2-flop synchroniser to give lock_sync. It is used only in that form.
- FSM states: IDLE, LOCK_WAIT, SETTLE. busy = (state != IDLE). req_ready = (state == IDLE) & ~fallback_cond. fallback_cond is 0 without the feature.
- IDLE, accepted request with req_sel == cur_sel: no-op. Handshake completes, no output changes, stay IDLE.
- IDLE, accepted request with req_sel=1, cur_sel=0: next cycle pll_en=1, counter=0, state=LOCK_WAIT.
- IDLE, accepted request with req_sel=0, cur_sel=1: next cycle sel_clk=0, counter=0, state=SETTLE. pll_en stays 1.
- LOCK_WAIT, lock_sync=1: next cycle sel_clk=1, counter=0, state=SETTLE. Lock takes priority over timeout in the same cycle.
- LOCK_WAIT, no lock: counter increments each cycle. When counter == LOCK_TIMEOUT-1 and lock_sync=0, next cycle pll_en=0, err_timeout=1, state=IDLE. cur_sel and sel_clk are unchanged (remain 0).
- SETTLE: counter increments each cycle. When counter == SETTLE_CYCLES-1, next cycle cur_sel=sel_clk, state=IDLE. If sel_clk=0, pll_en=0 in that same cycle. The PLL is never disabled while it is selected or settling.
- Latency, 0->1: minimum 1 (accept) + 2 (sync) + 1 (lock) + SETTLE_CYCLES until cur_sel=1, assuming lock asserts immediately.
- Latency, 1->0: 1 + SETTLE_CYCLES until cur_sel=0, with pll_en dropping the same cycle.
- Requests while busy are not accepted (req_ready=0). The requester holds req_valid.
- err_clr clears err_timeout and lock_lost. If set and clear occur in the same cycle, set wins.
- Lock loss during SETTLE or LOCK_WAIT is ignored by the FSM.
- Reset mid-sequence returns everything to reset values (sel_clk=0). The switch itself also resets to clk0.

Optional Feature:
CLK_SW_AUTO_FALLBACK_EN
- Enabled: fallback_cond = (state==IDLE) & cur_sel & ~lock_sync. When it is true, the next cycle sets sel_clk=0, lock_lost=1, counter=0, state=SETTLE. Completion then follows the normal 1->0 path, ending with pll_en=0 and cur_sel=0. Fallback beats a simultaneous request, since req_ready=0 in that cycle.
- Disabled: lock_lost is tied 0, loss of lock in IDLE is ignored, and req_ready = (state==IDLE).

Test Plan:
1. Reset, then req_sel=1 with lock asserted 5 cycles after pll_en -> pll_en=1 one cycle after accept; sel_clk=1 three cycles after lock rises; cur_sel=1 SETTLE_CYCLES later; busy drops the same cycle.
2. From cur_sel=1, req_sel=0 -> sel_clk=0 next cycle; after 16 cycles cur_sel=0 and pll_en=0 in the same cycle.
3. LOCK_TIMEOUT=32, lock never asserts -> pll_en falls and err_timeout=1 exactly 33 cycles after accept; sel_clk=0; cur_sel=0; busy=0. Then err_clr pulse -> err_timeout=0.
4. Back-to-back: req_sel=1 held valid while busy -> req_ready=0 throughout; request of req_sel=cur_sel -> accepted in one cycle with no output change.
5. rst_n asserted mid-SETTLE toward clk1 -> sel_clk, pll_en, cur_sel, busy all 0 immediately (asynchronously).
6. With CLK_SW_AUTO_FALLBACK_EN, cur_sel=1, drop pll_lock_async -> sel_clk=0 three cycles later, lock_lost=1, then pll_en=0 and cur_sel=0 after settle. Without the macro -> no output change.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequencer for the glitch-free clock switch and the PLL feeding its clk1 input.
//
// Accepts a clock-select request and, for a move to the PLL, enables the PLL. It then waits
// for synchronised lock, bounded by a timeout, before driving the switch select. After a fixed
// settle time it reports the new clock. On a move back to the reference clock it also powers
// the PLL down at that point. Runs on the always-on reference clock (the switch's clk0).
//
// Optional build macro: CLK_SW_AUTO_FALLBACK_EN
//   Falls back to clk0 automatically when the PLL loses lock while it is the clock in use,
//   and records the event in lock_lost.
//
// Ports:
//   clk            in   always-on reference clock
//   rst_n          in   asynchronous active-low reset
//   req_valid      in   switch request valid
//   req_sel        in   requested clock: 0 = clk0/ref, 1 = clk1/PLL
//   req_ready      out  request accepted when req_valid & req_ready
//   pll_lock_async in   PLL lock, asynchronous to clk
//   pll_en         out  PLL enable
//   sel_clk        out  select to the glitch-free switch
//   cur_sel        out  clock currently in effect (updated after settle)
//   busy           out  sequence in progress
//   err_timeout    out  sticky lock-timeout flag
//   err_clr        in   clears err_timeout and lock_lost
//   lock_lost      out  sticky lock-loss flag (0 without the fallback feature)

module clk_switch_ctrl #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic pll_lock_async,
  output logic pll_en,
  output logic sel_clk,
  output logic cur_sel,
  output logic busy,
  output logic err_timeout,
  input  logic err_clr,
  output logic lock_lost
);

  typedef enum logic [1:0] {
    StIdle,
    StLockWait,
    StSettle
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pll_en_q, pll_en_d;
  logic             sel_clk_q, sel_clk_d;
  logic             cur_sel_q, cur_sel_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_set;
  logic             lock_meta_q, lock_sync_q;
  logic             fallback_cond;

  // Two-flop synchroniser; lock is only ever consumed as lock_sync_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_async;
      lock_sync_q <= lock_meta_q;
    end
  end

`ifdef CLK_SW_AUTO_FALLBACK_EN
  logic lock_lost_q, lock_lost_d;

  // Lost lock while the PLL is the clock in use: retreat to clk0 ahead of any request.
  assign fallback_cond = (state_q == StIdle) & cur_sel_q & ~lock_sync_q;

  // Set wins over a simultaneous clear.
  always_comb begin
    lock_lost_d = lock_lost_q;
    if (fallback_cond) begin
      lock_lost_d = 1'b1;
    end else if (err_clr) begin
      lock_lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= lock_lost_d;
    end
  end

  assign lock_lost = lock_lost_q;
`else
  assign fallback_cond = 1'b0;
  assign lock_lost     = 1'b0;
`endif

  assign busy      = (state_q != StIdle);
  assign req_ready = (state_q == StIdle) & ~fallback_cond;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pll_en_d  = pll_en_q;
    sel_clk_d = sel_clk_q;
    cur_sel_d = cur_sel_q;
    err_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fallback_cond) begin
          sel_clk_d = 1'b0;
          cnt_d     = '0;
          state_d   = StSettle;
        end else if (req_valid && req_ready && (req_sel != cur_sel_q)) begin
          cnt_d = '0;
          if (req_sel) begin
            pll_en_d = 1'b1;
            state_d  = StLockWait;
          end else begin
            // PLL stays on until the switch has settled onto clk0.
            sel_clk_d = 1'b0;
            state_d   = StSettle;
          end
        end
      end
      StLockWait: begin
        // Lock beats a timeout expiring in the same cycle.
        if (lock_sync_q) begin
          sel_clk_d = 1'b1;
          cnt_d     = '0;
          state_d   = StSettle;
        end else if (cnt_q == TimeoutLast) begin
          pll_en_d = 1'b0;
          err_set  = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cur_sel_d = sel_clk_q;
          state_d   = StIdle;
          if (!sel_clk_q) begin
            pll_en_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Set wins over a simultaneous clear.
  always_comb begin
    err_timeout_d = err_timeout_q;
    if (err_set) begin
      err_timeout_d = 1'b1;
    end else if (err_clr) begin
      err_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      pll_en_q      <= 1'b0;
      sel_clk_q     <= 1'b0;
      cur_sel_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_en_q      <= pll_en_d;
      sel_clk_q     <= sel_clk_d;
      cur_sel_q     <= cur_sel_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign pll_en      = pll_en_q;
  assign sel_clk     = sel_clk_q;
  assign cur_sel     = cur_sel_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl. Each completed sequence is checked against an
// expectation queued when its request was driven: final outputs and cycles-to-idle.

module tb_clk_switch_ctrl;

  localparam int unsigned LockTimeout = 32;
  localparam int unsigned Settle      = 16;

  logic clk;
  logic rst_n;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic pll_lock_async;
  logic pll_en;
  logic sel_clk;
  logic cur_sel;
  logic busy;
  logic err_timeout;
  logic err_clr;
  logic lock_lost;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic cur_sel;
    logic pll_en;
    logic sel_clk;
    logic err_timeout;
    int   lat;
  } exp_t;

  exp_t sb[$];

  clk_switch_ctrl #(
    .CNT_W        (16),
    .LOCK_TIMEOUT (LockTimeout),
    .SETTLE_CYCLES(Settle)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_sel       (req_sel),
    .req_ready     (req_ready),
    .pll_lock_async(pll_lock_async),
    .pll_en        (pll_en),
    .sel_clk       (sel_clk),
    .cur_sel       (cur_sel),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr),
    .lock_lost     (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Count edges until busy drops (bounded), then compare against the oldest expectation.
  task automatic wait_idle(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      chk({tag, "_ready_while_busy"}, {31'd0, req_ready}, 32'd0);
      tick();
      n++;
    end
    chk({tag, "_idle_in_bound"}, {31'd0, busy}, 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_cur_sel"}, {31'd0, cur_sel}, {31'd0, e.cur_sel});
      chk({tag, "_pll_en"}, {31'd0, pll_en}, {31'd0, e.pll_en});
      chk({tag, "_sel_clk"}, {31'd0, sel_clk}, {31'd0, e.sel_clk});
      chk({tag, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, e.err_timeout});
    end
  endtask

  task automatic push(input logic c, input logic p, input logic s, input logic er, input int lat);
    exp_t e;
    e.cur_sel     = c;
    e.pll_en      = p;
    e.sel_clk     = s;
    e.err_timeout = er;
    e.lat         = lat;
    sb.push_back(e);
  endtask

  // Drive a one-cycle request and return just after the accepting edge.
  task automatic request(input logic sel);
    req_valid = 1'b1;
    req_sel   = sel;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_sel        = 1'b0;
    pll_lock_async = 1'b0;
    err_clr        = 1'b0;
    #23;
    chk("rst_pll_en", {31'd0, pll_en}, 32'd0);
    chk("rst_sel_clk", {31'd0, sel_clk}, 32'd0);
    chk("rst_cur_sel", {31'd0, cur_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_lock_lost", {31'd0, lock_lost}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    ticks(2);

    // 0 -> 1, lock arrives five cycles after pll_en.
    request(1'b1);
    chk("up_pll_en", {31'd0, pll_en}, 32'd1);
    chk("up_busy", {31'd0, busy}, 32'd1);
    chk("up_ready", {31'd0, req_ready}, 32'd0);
    ticks(4);
    pll_lock_async = 1'b1;
    ticks(2);
    chk("up_sel_before_sync", {31'd0, sel_clk}, 32'd0);
    tick();
    chk("up_sel_after_lock", {31'd0, sel_clk}, 32'd1);
    chk("up_cur_sel_pending", {31'd0, cur_sel}, 32'd0);
    push(1'b1, 1'b1, 1'b1, 1'b0, Settle);
    wait_idle("up");

    // 1 -> 0 with req_valid held; the same request then becomes a no-op.
    req_valid = 1'b1;
    req_sel   = 1'b0;
    tick();
    chk("down_sel_clk", {31'd0, sel_clk}, 32'd0);
    chk("down_pll_on", {31'd0, pll_en}, 32'd1);
    chk("down_cur_sel_held", {31'd0, cur_sel}, 32'd1);
    push(1'b0, 1'b0, 1'b0, 1'b0, Settle);
    wait_idle("down");
    chk("noop_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("noop_busy", {31'd0, busy}, 32'd0);
    chk("noop_pll_en", {31'd0, pll_en}, 32'd0);
    chk("noop_cur_sel", {31'd0, cur_sel}, 32'd0);

    // Lock never arrives: timeout after LockTimeout edges.
    pll_lock_async = 1'b0;
    ticks(3);
    request(1'b1);
    chk("to_pll_en", {31'd0, pll_en}, 32'd1);
    push(1'b0, 1'b0, 1'b0, 1'b1, LockTimeout);
    wait_idle("timeout");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_cleared", {31'd0, err_timeout}, 32'd0);

    // Reset mid-SETTLE toward clk1 clears outputs without a clock edge.
    pll_lock_async = 1'b1;
    ticks(3);
    request(1'b1);
    tick();
    chk("rst2_sel_clk_set", {31'd0, sel_clk}, 32'd1);
    ticks(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_sel_clk", {31'd0, sel_clk}, 32'd0);
    chk("rst2_pll_en", {31'd0, pll_en}, 32'd0);
    chk("rst2_cur_sel", {31'd0, cur_sel}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    #4;
    rst_n = 1'b1;
    ticks(3);

    // Reach clk1 with lock already stable, then drop lock in IDLE.
    request(1'b1);
    push(1'b1, 1'b1, 1'b1, 1'b0, Settle + 1);
    wait_idle("up2");
    pll_lock_async = 1'b0;
`ifdef CLK_SW_AUTO_FALLBACK_EN
    ticks(2);
    chk("fb_ready_blocked", {31'd0, req_ready}, 32'd0);
    chk("fb_sel_still_1", {31'd0, sel_clk}, 32'd1);
    tick();
    chk("fb_sel_clk", {31'd0, sel_clk}, 32'd0);
    chk("fb_lock_lost", {31'd0, lock_lost}, 32'd1);
    chk("fb_pll_on", {31'd0, pll_en}, 32'd1);
    push(1'b0, 1'b0, 1'b0, 1'b0, Settle);
    wait_idle("fallback");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("fb_lock_lost_cleared", {31'd0, lock_lost}, 32'd0);
`else
    ticks(Settle + 4);
    chk("nofb_sel_clk", {31'd0, sel_clk}, 32'd1);
    chk("nofb_cur_sel", {31'd0, cur_sel}, 32'd1);
    chk("nofb_pll_en", {31'd0, pll_en}, 32'd1);
    chk("nofb_busy", {31'd0, busy}, 32'd0);
    chk("nofb_lock_lost", {31'd0, lock_lost}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
